// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the divide-by-zero quotient fill value.
package seq_restoring_divider_pkg;

  localparam int DEF_WIDTH = 32;

  // A divide-by-zero quotient is all ones at whatever WIDTH is in use.
  localparam logic DBZ_QUOTIENT_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle between the ALU control (master) and the divider (slave).
interface seq_restoring_divider_if
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             START;
  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             DIV_BY_ZERO;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell; chained by borrow to build the trial subtractor.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic DIFF,
  output logic BOUT
);

  assign DIFF = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, trial subtraction
// through a ripple-borrow chain of full_subtractor cells.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic                 CLK,
  input logic                 RST,
  seq_restoring_divider_if.slave bus
);

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   q_r, q_s;
  logic [WIDTH-1:0]   d_r, d_s;
  logic [WIDTH:0]     r_r, r_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [WIDTH-1:0]   quotient_r, quotient_s;
  logic [WIDTH-1:0]   remainder_r, remainder_s;
  logic               dbz_r, dbz_s;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH:0]     r_shift_s;
  logic [WIDTH:0]     sub_b_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH+1:0]   borrow_s;
  logic               restore_s;

  // R always stays below D, so only its low WIDTH bits feed the next shift.
  assign r_shift_s   = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign sub_b_s     = {1'b0, d_r};
  assign borrow_s[0] = 1'b0;
  assign restore_s   = borrow_s[WIDTH+1];

  genvar i;
  for (i = 0; i < WIDTH + 1; i++) begin : g_sub
    full_subtractor u_fs (
      .A    (r_shift_s[i]),
      .B    (sub_b_s[i]),
      .BIN  (borrow_s[i]),
      .DIFF (diff_s[i]),
      .BOUT (borrow_s[i+1])
    );
  end

  // Next-state, datapath and result logic.
  always_comb begin
    state_s     = state_r;
    q_s         = q_r;
    d_s         = d_r;
    r_s         = r_r;
    cnt_s       = cnt_r;
    quotient_s  = quotient_r;
    remainder_s = remainder_r;
    dbz_s       = dbz_r;
    case (state_r)
      IDLE, FINISH: begin
        if (bus.START) begin
          if (bus.DIVISOR != '0) begin
            q_s         = bus.DIVIDEND;
            d_s         = bus.DIVISOR;
            r_s         = '0;
            cnt_s       = CNT_W'(WIDTH);
            quotient_s  = '0;
            remainder_s = '0;
            dbz_s       = 1'b0;
            state_s     = RUN;
          end else begin
            quotient_s  = {WIDTH{DBZ_QUOTIENT_BIT}};
            remainder_s = bus.DIVIDEND;
            dbz_s       = 1'b1;
            state_s     = FINISH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        r_s   = restore_s ? r_shift_s : diff_s;
        q_s   = {q_r[WIDTH-2:0], ~restore_s};
        cnt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          quotient_s  = q_s;
          remainder_s = r_s[WIDTH-1:0];
          state_s     = FINISH;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs; BUSY/DONE follow the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r         <= '0;
      d_r         <= '0;
      r_r         <= '0;
      cnt_r       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      q_r         <= q_s;
      d_r         <= d_s;
      r_r         <= r_s;
      cnt_r       <= cnt_s;
      quotient_r  <= quotient_s;
      remainder_r <= remainder_s;
      dbz_r       <= dbz_s;
      busy_r      <= (state_s == RUN);
      done_r      <= (state_s == FINISH);
    end
  end

  assign bus.BUSY        = busy_r;
  assign bus.DONE        = done_r;
  assign bus.QUOTIENT    = quotient_r;
  assign bus.REMAINDER   = remainder_r;
  assign bus.DIV_BY_ZERO = dbz_r;

endmodule
